// File: rtl/reorder_fifo_pp.sv
// Ping-pong reorder FIFO: out-of-order fill of one bank, in-order drain of the other.
// Optional REORDER_EARLY_RELEASE_EN lets the reader drain a bank while it is still filling.
module reorder_fifo_pp #(
  parameter int DW = 18,
  parameter int AW = 7
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic [DW-1:0] data_in,
  input  logic [AW-1:0] data_offset,
  output logic          rdy,
  output logic          dup_err,
  output logic          ovf_err,
  input  logic          pop,
  output logic          vld,
  output logic [DW-1:0] data_out,
  output logic          empty,
  output logic          fill_bank,
  output logic          drain_bank
);
  localparam int DEPTH = 1 << AW;
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {
    EMPTY,
    FILLING,
    SEALED,
    DRAINING
  } bank_st_t;

  bank_st_t             st [2];
  logic [CW-1:0]        cnt [2];
  logic [1:0][DEPTH-1:0] written;
  logic [DW-1:0]        mem [2*DEPTH];

  logic                 wr_en;
  logic [AW:0]          wr_addr;
  logic [DW-1:0]        wr_data;
  logic                 rd_busy;
  logic [AW-1:0]        rd_ptr;

  logic fill_full;
  logic hit;
  logic accept;
  logic seal;
  logic fill_go;
  logic head_ok;
  logic sel_ok;
  logic nxt_ok;
  logic select;
  logic issue;
  logic last;

  assign fill_full = cnt[fill_bank] == CW'(DEPTH);
  assign rdy       = !fill_full;
  assign hit       = written[fill_bank][data_offset];
  assign accept    = push && rdy && !hit;
  assign seal      = accept && cnt[fill_bank] == CW'(DEPTH-1);
  assign fill_go   = (seal || fill_full) && st[~fill_bank] == EMPTY;

`ifdef REORDER_EARLY_RELEASE_EN
  // Head entry must be written and already landed in the RAM.
  assign head_ok = written[drain_bank][rd_ptr] &&
                   !(wr_en && wr_addr == {drain_bank, rd_ptr});
  assign sel_ok  = st[drain_bank] == SEALED ||
                   st[drain_bank] == FILLING;
  assign nxt_ok  = st[~drain_bank] == SEALED ||
                   st[~drain_bank] == FILLING;
`else
  assign head_ok = 1'b1;
  assign sel_ok  = st[drain_bank] == SEALED;
  assign nxt_ok  = st[~drain_bank] == SEALED;
`endif

  assign select = !rd_busy && sel_ok;
  assign issue  = rd_busy && head_ok && (!vld || pop);
  assign last   = issue && rd_ptr == AW'(DEPTH-1);
  assign empty  = !vld && st[0] == EMPTY && st[1] == EMPTY;

  // Registered RAM write port, one cycle behind acceptance.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  // Bank FSMs, fill/drain pointers, read-ahead output register and error pulses.
  always_ff @(posedge clk) begin
    if (rst) begin
      st[0]      <= EMPTY;
      st[1]      <= EMPTY;
      cnt[0]     <= '0;
      cnt[1]     <= '0;
      written    <= '0;
      wr_en      <= 1'b0;
      wr_addr    <= '0;
      wr_data    <= '0;
      rd_busy    <= 1'b0;
      rd_ptr     <= '0;
      vld        <= 1'b0;
      data_out   <= '0;
      dup_err    <= 1'b0;
      ovf_err    <= 1'b0;
      fill_bank  <= 1'b0;
      drain_bank <= 1'b0;
    end else begin
      ovf_err <= push && !rdy;
      dup_err <= push && rdy && hit;
      wr_en   <= accept;
      wr_addr <= {fill_bank, data_offset};
      wr_data <= data_in;
      if (accept) begin
        written[fill_bank][data_offset] <= 1'b1;
        cnt[fill_bank] <= cnt[fill_bank] + 1'b1;
        if (seal) st[fill_bank] <= SEALED;
        else if (st[fill_bank] == EMPTY)
          st[fill_bank] <= FILLING;
      end
      if (fill_go) fill_bank <= ~fill_bank;
      if (select) begin
        rd_busy <= 1'b1;
        rd_ptr  <= '0;
        if (st[drain_bank] == SEALED)
          st[drain_bank] <= DRAINING;
      end
      if (issue) begin
        data_out <= mem[{drain_bank, rd_ptr}];
        vld      <= 1'b1;
        rd_ptr   <= rd_ptr + 1'b1;
      end else if (pop) begin
        vld <= 1'b0;
      end
      if (last) begin
        st[drain_bank]      <= EMPTY;
        cnt[drain_bank]     <= '0;
        written[drain_bank] <= '0;
        drain_bank          <= ~drain_bank;
        rd_busy             <= nxt_ok;
        if (st[~drain_bank] == SEALED)
          st[~drain_bank] <= DRAINING;
      end
    end
  end
endmodule

// File: tb/tb_reorder_fifo_pp.sv
// Testbench for reorder_fifo_pp (AW=2): scoreboard against a bank-level model,
// directed reset/ping-pong/duplicate/overflow cases plus randomized fills.
module tb_reorder_fifo_pp;
  localparam int DW = 18;
  localparam int AW = 2;
  localparam int DEPTH = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          push = 1'b0;
  logic          pop = 1'b0;
  logic [DW-1:0] data_in = '0;
  logic [AW-1:0] data_offset = '0;
  logic          rdy, dup_err, ovf_err, vld, empty;
  logic          fill_bank, drain_bank;
  logic [DW-1:0] data_out;

  int tests = 0;
  int fails = 0;
  int n_pop = 0;
  int n_dup = 0;
  int n_ovf = 0;
  int exp_dup = 0;
  int exp_ovf = 0;
  int completed = 0;
  int pop_mode = 0;

  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] mdat[DEPTH];
  bit            mwr[DEPTH];
  int            mcnt = 0;
  int            mrel = 0;

  reorder_fifo_pp #(.DW(DW), .AW(AW)) dut (
    .clk(clk), .rst(rst),
    .push(push), .data_in(data_in),
    .data_offset(data_offset),
    .rdy(rdy), .dup_err(dup_err),
    .ovf_err(ovf_err), .pop(pop),
    .vld(vld), .data_out(data_out),
    .empty(empty), .fill_bank(fill_bank),
    .drain_bank(drain_bank)
  );

  always #5 clk = ~clk;

  task automatic check(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h",
               name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Monitor: compare every handshake against the scoreboard.
  initial forever begin
    @(negedge clk);
    if (!rst) begin
      if (dup_err) n_dup++;
      if (ovf_err) n_ovf++;
      if (vld && pop) begin
        n_pop++;
        if (exp_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL underrun: got %0h expected none",
                   data_out);
        end else begin
          check("data_out", data_out, exp_q.pop_front());
        end
      end
    end
  end

  // Random consumer.
  initial forever begin
    @(posedge clk);
    #2;
    if (pop_mode == 2) pop = ($urandom_range(0, 3) != 0);
  end

  task automatic model_reset();
    exp_q.delete();
    for (int i = 0; i < DEPTH; i++) mwr[i] = 0;
    mcnt = 0;
    mrel = 0;
    completed = 0;
    n_pop = 0;
  endtask

  // Bank-level model: a bank is released in offset order once
  // complete (or, with early release, as its in-order prefix grows).
  task automatic push_m(input int off, input logic [DW-1:0] d);
    if (completed - n_pop / DEPTH >= 2) begin
      exp_ovf++;
    end else if (mwr[off]) begin
      exp_dup++;
    end else begin
      mwr[off] = 1;
      mdat[off] = d;
      mcnt++;
`ifdef REORDER_EARLY_RELEASE_EN
      while (mrel < DEPTH && mwr[mrel]) begin
        exp_q.push_back(mdat[mrel]);
        mrel++;
      end
`endif
      if (mcnt == DEPTH) begin
`ifndef REORDER_EARLY_RELEASE_EN
        for (int i = 0; i < DEPTH; i++) exp_q.push_back(mdat[i]);
`endif
        completed++;
        for (int i = 0; i < DEPTH; i++) mwr[i] = 0;
        mcnt = 0;
        mrel = 0;
      end
    end
    push = 1'b1;
    data_offset = AW'(off);
    data_in = d;
    @(posedge clk);
    #1;
    push = 1'b0;
  endtask

  task automatic wait_vld();
    int k = 0;
    while (!vld && k < 50) begin
      tick(1);
      k++;
    end
    check("vld_wait", vld, 1);
  endtask

  task automatic wait_room();
    int k = 0;
    while (completed - n_pop / DEPTH > 1 && k < 500) begin
      tick(1);
      k++;
    end
    check("room_wait", k < 500, 1);
    tick(3);
  endtask

  task automatic wait_done(input string name);
    int k = 0;
    pop_mode = 2;
    while (!(exp_q.size() == 0 && empty) && k < 2000) begin
      tick(1);
      k++;
    end
    pop_mode = 0;
    pop = 1'b0;
    check({name, "_drained"}, exp_q.size(), 0);
    check({name, "_empty"}, empty, 1);
  endtask

  task automatic fill_perm(input logic [DW-1:0] base);
    int p[4];
    int j, t;
    for (int i = 0; i < 4; i++) p[i] = i;
    for (int i = 3; i > 0; i--) begin
      j = $urandom_range(0, i);
      t = p[i];
      p[i] = p[j];
      p[j] = t;
    end
    for (int i = 0; i < 4; i++)
      push_m(p[i], base + DW'(p[i]));
  endtask

  initial begin
    int d0;
    // Reset state
    tick(2);
    check("rst_rdy", rdy, 1);
    check("rst_empty", empty, 1);
    check("rst_vld", vld, 0);
    check("rst_dup", dup_err, 0);
    check("rst_ovf", ovf_err, 0);
    check("rst_fill", fill_bank, 0);
    check("rst_drain", drain_bank, 0);
    check("rst_dout", data_out, 0);
    rst = 1'b0;
    tick(1);

    // Out-of-order fill of one bank, in-order drain
    push_m(3, 18'h0A3);
    push_m(1, 18'h0A1);
    push_m(0, 18'h0A0);
    push_m(2, 18'h0A2);
    check("seal_fill_bank", fill_bank, 1);
`ifndef REORDER_EARLY_RELEASE_EN
    check("vld_lat0", vld, 0);
    tick(1);
    check("vld_lat1", vld, 0);
    tick(1);
    check("vld_lat2", vld, 1);
`endif
    wait_vld();
    d0 = n_pop;
    pop = 1'b1;
    tick(4);
    pop = 1'b0;
    check("b2b_pops", n_pop - d0, 4);
    check("t2_empty", empty, 1);

    // Ping-pong: two banks back to back, then overflow
    fill_perm(18'h100);
    fill_perm(18'h200);
    check("both_full_rdy", rdy, 0);
    push_m(1, 18'h3FF);
    check("ovf_pulse", ovf_err, 1);
    check("ovf_rdy", rdy, 0);
    tick(1);
    check("ovf_once", ovf_err, 0);
    d0 = n_pop;
    pop = 1'b1;
    tick(8);
    pop = 1'b0;
    check("pp_no_bubble", n_pop - d0, 8);
    check("pp_empty", empty, 1);
    check("pp_scoreboard", exp_q.size(), 0);
    tick(2);
    check("pp_vld_off", vld, 0);

    // Duplicate offset keeps the first data
    push_m(2, 18'h00C1);
    push_m(2, 18'h00C2);
    check("dup_pulse", dup_err, 1);
    tick(1);
    check("dup_once", dup_err, 0);
    push_m(0, 18'h00C0);
    push_m(3, 18'h00C3);
    push_m(1, 18'h00C4);
    wait_done("dup");

`ifdef REORDER_EARLY_RELEASE_EN
    // In-order release from a bank that is still filling
    d0 = n_pop;
    pop = 1'b1;
    push_m(0, 18'h0E0);
    push_m(1, 18'h0E1);
    push_m(3, 18'h0E3);
    tick(6);
    check("early_two", n_pop - d0, 2);
    check("early_hole", vld, 0);
    push_m(2, 18'h0E2);
    tick(6);
    pop = 1'b0;
    check("early_all", n_pop - d0, 4);
    check("early_free", empty, 1);
`endif

    // Reset in the middle of a drain
    fill_perm(18'h500);
    wait_vld();
    d0 = n_pop;
    pop = 1'b1;
    tick(2);
    pop = 1'b0;
    check("mid_pops", n_pop - d0, 2);
    rst = 1'b1;
    model_reset();
    tick(1);
    check("mid_rst_empty", empty, 1);
    check("mid_rst_vld", vld, 0);
    check("mid_rst_rdy", rdy, 1);
    check("mid_rst_dup", dup_err, 0);
    check("mid_rst_ovf", ovf_err, 0);
    check("mid_rst_fill", fill_bank, 0);
    rst = 1'b0;
    tick(1);
    fill_perm(18'h600);
    wait_done("post_rst");

    // Randomized fills with duplicates and a random consumer
    pop_mode = 2;
    for (int r = 0; r < 10; r++) begin
      int p[4];
      int j, t;
      wait_room();
      for (int i = 0; i < 4; i++) p[i] = i;
      for (int i = 3; i > 0; i--) begin
        j = $urandom_range(0, i);
        t = p[i];
        p[i] = p[j];
        p[j] = t;
      end
      for (int i = 0; i < 4; i++) begin
        if (i > 0 && $urandom_range(0, 3) == 0)
          push_m(p[$urandom_range(0, i - 1)], DW'($urandom));
        push_m(p[i], DW'($urandom));
        if ($urandom_range(0, 2) == 0) tick(1);
      end
    end
    wait_done("rand");

    check("dup_count", n_dup, exp_dup);
    check("ovf_count", n_ovf, exp_ovf);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
